nes_controller_reader: RTL and testbench

// Polls the NES game-pad over its 3-wire serial interface (latch, pulse, data) once per poll period.

---
 rtl/nes_controller_reader_if.sv | 26 ++
 rtl/nes_controller_reader.sv | 145 ++++++++++++++
 tb/tb_nes_controller_reader.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/nes_controller_reader_if.sv
// nes_controller_reader_if
// Bundles the game-pad serial wires (nes_latch, nes_pulse, nes_data) and the
// decoded button outputs (buttons, up/down/left/right, valid).
//   master : the reader. Drives latch/pulse/buttons/valid and samples nes_data.
//   slave  : the pad side and the consumers. Drives nes_data and observes the rest.
interface nes_controller_reader_if;
  logic       nes_latch;
  logic       nes_pulse;
  logic       nes_data;
  logic [7:0] buttons;
  logic       up;
  logic       down;
  logic       left;
  logic       right;
  logic       valid;

  modport master (
    output nes_latch, nes_pulse, buttons, up, down, left, right, valid,
    input  nes_data
  );

  modport slave (
    input  nes_latch, nes_pulse, buttons, up, down, left, right, valid,
    output nes_data
  );
endinterface

// File: rtl/nes_controller_reader.sv
// nes_controller_reader
// Polls an NES game-pad once per poll period and presents the eight buttons
// as registered active-high bits.
// Ports:
//   inputclk : system clock, rising edge
//   reset    : synchronous, active-high
//   bus      : nes_controller_reader_if.master
//              nes_latch/nes_pulse out to the pad, nes_data in (active-low),
//              buttons[7:0] = {Right,Left,Down,Up,Start,Select,B,A},
//              up/down/left/right = buttons[4..7],
//              valid = one-cycle strobe on every buttons update
module nes_controller_reader #(
  parameter int POLL_CYCLES  = 833_333,
  parameter int LATCH_CYCLES = 600,
  parameter int HALF_CYCLES  = 150
) (
  input logic                      inputclk,
  input logic                      reset,
  nes_controller_reader_if.master  bus
);

  localparam int PW     = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int PH_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int HW     = $clog2(PH_MAX);

  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYCLES - 1);
  localparam logic [HW-1:0] LATCH_LAST = HW'(LATCH_CYCLES - 1);
  localparam logic [HW-1:0] HALF_LAST  = HW'(HALF_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_LOW, S_HIGH} state_t;

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_poll;
  logic [HW-1:0] r_phase, w_phase_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic [7:0]    r_buttons, w_buttons_nxt;
  logic          r_valid, w_valid_nxt;
  logic          r_latch, r_pulse;
  logic [1:0]    r_sync;
  logic          w_data_s;
  logic          w_poll_wrap;

  assign w_data_s    = r_sync[1];
  assign w_poll_wrap = (r_poll == POLL_LAST);

  // Free-running poll timebase; only the wrap cycle matters, and only in IDLE.
  always_ff @(posedge inputclk) begin
    if (reset)            r_poll <= '0;
    else if (w_poll_wrap) r_poll <= '0;
    else                  r_poll <= r_poll + PW'(1);
  end

  // nes_data is asynchronous to inputclk.
  always_ff @(posedge inputclk) begin
    if (reset) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], bus.nes_data};
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_phase_nxt   = r_phase;
    w_bit_nxt     = r_bit;
    w_shift_nxt   = r_shift;
    w_buttons_nxt = r_buttons;
    w_valid_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_phase_nxt = '0;
        if (w_poll_wrap) w_state_nxt = S_LATCH;
      end
      S_LATCH: begin
        if (r_phase == LATCH_LAST) begin
          w_state_nxt = S_LOW;
          w_phase_nxt = '0;
          w_bit_nxt   = 3'd0;
        end else begin
          w_phase_nxt = r_phase + HW'(1);
        end
      end
      S_LOW: begin
        if (r_phase == HALF_LAST) begin
          // Sample as late as possible in the low phase: the pad has had the
          // whole previous high+low time to settle after its shift.
          w_shift_nxt[r_bit] = ~w_data_s;
          w_state_nxt        = S_HIGH;
          w_phase_nxt        = '0;
        end else begin
          w_phase_nxt = r_phase + HW'(1);
        end
      end
      S_HIGH: begin
        if (r_phase == HALF_LAST) begin
          w_phase_nxt = '0;
          if (r_bit == 3'd7) begin
            // Whole-vector load so consumers never see a partial frame.
            w_state_nxt   = S_IDLE;
            w_buttons_nxt = r_shift;
            w_valid_nxt   = 1'b1;
          end else begin
            w_bit_nxt   = r_bit + 3'd1;
            w_state_nxt = S_LOW;
          end
        end else begin
          w_phase_nxt = r_phase + HW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // latch/pulse are decoded from the next state so they switch on the same
  // edge as the state register and stay glitch-free at the pins.
  always_ff @(posedge inputclk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_phase   <= '0;
      r_bit     <= 3'd0;
      r_shift   <= 8'h00;
      r_buttons <= 8'h00;
      r_valid   <= 1'b0;
      r_latch   <= 1'b0;
      r_pulse   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_phase   <= w_phase_nxt;
      r_bit     <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_buttons <= w_buttons_nxt;
      r_valid   <= w_valid_nxt;
      r_latch   <= (w_state_nxt == S_LATCH);
      r_pulse   <= (w_state_nxt == S_HIGH);
    end
  end

  assign bus.nes_latch = r_latch;
  assign bus.nes_pulse = r_pulse;
  assign bus.buttons   = r_buttons;
  assign bus.valid     = r_valid;
  assign bus.up        = r_buttons[4];
  assign bus.down      = r_buttons[5];
  assign bus.left      = r_buttons[6];
  assign bus.right     = r_buttons[7];

endmodule

// File: tb/tb_nes_controller_reader.sv
module tb_nes_controller_reader;

  localparam int POLL  = 100;
  localparam int LATCH = 4;
  localparam int HALF  = 3;

  logic inputclk = 1'b0;
  logic reset    = 1'b1;
  always #5 inputclk = ~inputclk;

  nes_controller_reader_if bus ();

  nes_controller_reader #(
    .POLL_CYCLES (POLL),
    .LATCH_CYCLES(LATCH),
    .HALF_CYCLES (HALF)
  ) dut (
    .inputclk(inputclk),
    .reset   (reset),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Pad model: parallel-load on latch rise, shift on every pulse rise.
  // pad_n is active-low, bit i is the i-th serial bit.
  logic [7:0] pad_n     = 8'hFF;
  logic [7:0] frame_pad = 8'hFF;
  logic       tie_hi    = 1'b0;
  int         idx       = 8;

  always @(posedge bus.nes_latch or posedge bus.nes_pulse) begin
    if (bus.nes_latch) begin
      idx       = 0;
      frame_pad = pad_n;
    end else begin
      idx = idx + 1;
    end
  end

  assign bus.nes_data = tie_hi ? 1'b1 : ((idx < 8) ? frame_pad[idx[2:0]] : 1'b1);

  int cyc = 0;
  always @(posedge inputclk) cyc <= cyc + 1;

  // Monitor / scoreboard, sampling on the falling edge.
  logic [7:0] sb[$];
  int   nvalid      = 0;
  int   latch_cyc   = 0;
  int   exp_latch   = -1;
  int   prise       = 0;
  int   pfall       = 0;
  int   pulses      = 0;
  logic p_latch     = 1'b0;
  logic p_pulse     = 1'b0;
  logic p_valid     = 1'b0;
  logic p_rst       = 1'b0;
  logic [7:0] p_buttons = 8'h00;

  always @(negedge inputclk) begin
    if (reset) begin
      p_rst = 1'b1;
      sb.delete();
      exp_latch = -1;
    end else if (p_rst) begin
      chk("rst_latch",   bus.nes_latch, 0);
      chk("rst_pulse",   bus.nes_pulse, 0);
      chk("rst_buttons", bus.buttons,   0);
      chk("rst_valid",   bus.valid,     0);
      exp_latch = cyc + POLL;
      pulses    = 0;
      p_rst     = 1'b0;
    end else begin
      if (bus.nes_latch && !p_latch) begin
        chk("latch_time", cyc, exp_latch);
        latch_cyc = cyc;
        exp_latch = cyc + POLL;
        pulses    = 0;
        sb.push_back(tie_hi ? 8'h00 : ~frame_pad);
      end
      if (!bus.nes_latch && p_latch) chk("latch_width", cyc - latch_cyc, LATCH);
      if (bus.nes_pulse && !p_pulse) begin
        pulses++;
        if (bus.nes_latch) chk("pulse_in_latch", 1, 0);
        if (pulses > 1) chk("pulse_low", cyc - pfall, HALF);
        prise = cyc;
      end
      if (!bus.nes_pulse && p_pulse) begin
        chk("pulse_high", cyc - prise, HALF);
        pfall = cyc;
      end
      if (bus.valid) begin
        nvalid++;
        chk("valid_1cyc",  p_valid, 0);
        chk("latency",     cyc - latch_cyc, LATCH + 16 * HALF);
        chk("pulse_count", pulses, 8);
        if (sb.size() == 0) begin
          chk("sb_empty", 1, 0);
        end else begin
          logic [7:0] e;
          e = sb.pop_front();
          chk("buttons", bus.buttons, e);
          chk("dirs", {bus.right, bus.left, bus.down, bus.up}, e[7:4]);
        end
      end else begin
        chk("stable", bus.buttons, p_buttons);
      end
    end
    p_latch   = bus.nes_latch;
    p_pulse   = bus.nes_pulse;
    p_valid   = bus.valid;
    p_buttons = bus.buttons;
  end

  task automatic wait_valid(input int n);
    int  tgt;
    bit  hit;
    tgt = nvalid + n;
    hit = 1'b0;
    for (int i = 0; i < n * 3 * POLL && !hit; i++) begin
      @(posedge inputclk);
      if (nvalid >= tgt) hit = 1'b1;
    end
    if (!hit) chk("timeout_valid", nvalid, tgt);
  endtask

  task automatic wait_latch();
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 3 * POLL && !hit; i++) begin
      @(posedge inputclk);
      #1;
      if (bus.nes_latch) hit = 1'b1;
    end
    if (!hit) chk("timeout_latch", 0, 1);
  endtask

  initial begin
    // A + Up pressed: serial 0,1,1,1,0,1,1,1 -> 8'h11
    pad_n = 8'b1110_1110;
    repeat (3) @(posedge inputclk);
    #1 reset = 1'b0;
    wait_valid(2);

    // Disconnected pad
    tie_hi = 1'b1;
    wait_valid(2);

    // Right only
    tie_hi = 1'b0;
    pad_n  = 8'h7F;
    wait_valid(1);

    // Change pressed set part-way through a frame: that frame keeps the
    // old set, the following one picks up the new one.
    wait_latch();
    repeat (10) @(posedge inputclk);
    pad_n = 8'hF0;
    wait_valid(2);

    // Reset in the 3rd pulse high phase.
    pad_n = 8'b1010_1010;
    wait_latch();
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 3 * POLL && !hit; i++) begin
        @(posedge inputclk);
        #1;
        if (bus.nes_pulse && idx == 3) hit = 1'b1;
      end
      if (!hit) chk("timeout_pulse3", 0, 1);
    end
    reset = 1'b1;
    @(posedge inputclk);
    #1 reset = 1'b0;
    wait_valid(2);

    repeat (5) @(posedge inputclk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
